// File: rtl/alu_issue_stage_if.sv
// Port bundle for the ALU issue stage: decoder handshake, write-back
// forwarding port and the registered operand bundle toward the ALU.
interface alu_issue_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_alu_control;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [XLEN-1:0]   in_rs1_data;
    logic [XLEN-1:0]   in_rs2_data;
    logic [XLEN-1:0]   in_imm;
    logic [REG_AW-1:0] in_rd;
    logic              in_reg_write;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [2:0]        alu_control;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write;
    logic              illegal_op;

    // The stage itself.
    modport slave (
        input  flush, in_valid, in_alu_control, in_rs1, in_rs2, in_rs1_data,
               in_rs2_data, in_imm, in_rd, in_reg_write, wb_valid, wb_rd,
               wb_data, out_ready,
        output in_ready, out_valid, src_a, src_b, alu_control, out_rd,
               out_reg_write, illegal_op
    );

    // Decoder / ALU side environment.
    modport master (
        output flush, in_valid, in_alu_control, in_rs1, in_rs2, in_rs1_data,
               in_rs2_data, in_imm, in_rd, in_reg_write, wb_valid, wb_rd,
               wb_data, out_ready,
        input  in_ready, out_valid, src_a, src_b, alu_control, out_rd,
               out_reg_write, illegal_op
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand select, write-back forwarding and a 2-entry
// skid buffer (main + skid) so in_ready comes straight from a flop.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_stage_if.slave     bus
);
    typedef struct packed {
        logic [2:0]        op;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              b_reg;
        logic              rw;
    } entry_t;

    // Replace any register-sourced operand that the active write-back targets.
    function automatic entry_t fwd(input entry_t e, input logic wv,
                                   input logic [REG_AW-1:0] wrd,
                                   input logic [XLEN-1:0] wd);
        entry_t r = e;
        if (wv && wrd != '0) begin
            if (e.rs1 == wrd)            r.a = wd;
            if (e.b_reg && e.rs2 == wrd) r.b = wd;
        end
        return r;
    endfunction

    entry_t main_q, main_d, skid_q, skid_d, cap;
    logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic   in_ready_q, in_ready_d, illegal_q, illegal_d;
    logic   accept, drain, illegal_in;

    assign accept     = bus.in_valid && in_ready_q;
    assign drain      = main_vld_q && bus.out_ready;
    assign illegal_in = (bus.in_alu_control == 3'b001);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cap       = '0;
        cap.op    = illegal_in ? 3'b000 : bus.in_alu_control;
        cap.rs1   = bus.in_rs1;
        cap.rs2   = bus.in_rs2;
        cap.rd    = bus.in_rd;
        cap.b_reg = (bus.in_alu_control[2:1] != 2'b11);
        cap.a     = bus.in_rs1_data;
        cap.b     = cap.b_reg ? bus.in_rs2_data : bus.in_imm;
        cap.rw    = bus.in_reg_write && !illegal_in && (bus.in_rd != '0);
        cap       = fwd(cap, bus.wb_valid, bus.wb_rd, bus.wb_data);
    end

    always_comb begin
        main_d     = fwd(main_q, bus.wb_valid, bus.wb_rd, bus.wb_data);
        skid_d     = fwd(skid_q, bus.wb_valid, bus.wb_rd, bus.wb_data);
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        illegal_d  = illegal_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            if (accept && illegal_in) illegal_d = 1'b1;
            if (!main_vld_q || drain) begin
                // A full skid implies in_ready was low, so no accept can collide.
                if (skid_vld_q) begin
                    main_d     = skid_d;
                    main_vld_d = 1'b1;
                    skid_vld_d = 1'b0;
                end else if (accept) begin
                    main_d     = cap;
                    main_vld_d = 1'b1;
                end else begin
                    main_vld_d = 1'b0;
                end
            end else if (accept) begin
                skid_d     = cap;
                skid_vld_d = 1'b1;
            end
        end
        in_ready_d = !skid_vld_d;
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            illegal_q  <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = main_vld_q;
    assign bus.src_a         = main_q.a;
    assign bus.src_b         = main_q.b;
    assign bus.alu_control   = main_q.op;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_reg_write = main_q.rw;
    assign bus.illegal_op    = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed vectors push expected
// bundles; a negedge monitor pops and compares on every output transfer.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;
    exp_t exp_q[$];

    alu_issue_stage_if #(.XLEN(32), .REG_AW(5)) bus ();
    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed output transfer against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("src_a", bus.src_a, e.a);
                check("src_b", bus.src_b, e.b);
                check("alu_control", {29'd0, bus.alu_control}, {29'd0, e.op});
                check("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
                check("out_reg_write", {31'd0, bus.out_reg_write}, {31'd0, e.rw});
            end
        end
    end

    // Called just after a posedge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [4:0] rd, input logic rw,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [2:0] eop, input logic erw);
        int t;
        exp_t e;
        bus.in_valid       = 1'b1;
        bus.in_alu_control = op;
        bus.in_rs1         = rs1;
        bus.in_rs2         = rs2;
        bus.in_rs1_data    = d1;
        bus.in_rs2_data    = d2;
        bus.in_imm         = imm;
        bus.in_rd          = rd;
        bus.in_reg_write   = rw;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) begin
            check("issue_timeout", 32'd1, 32'd0);
            bus.in_valid = 1'b0;
            return;
        end
        e.a = ea; e.b = eb; e.op = eop; e.rd = rd; e.rw = erw;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.in_alu_control = 0; bus.in_rs1 = 0;
        bus.in_rs2 = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
        bus.in_rd = 0; bus.in_reg_write = 0; bus.wb_valid = 0; bus.wb_rd = 0;
        bus.wb_data = 0; bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_src_a", bus.src_a, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal_op}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ADD, one-cycle latency.
        issue(3'b010, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 32'd5, 32'd7, 3'b010, 1'b1);
        check("add_latency_valid", {31'd0, bus.out_valid}, 32'd1);
        // ADDI picks immediate; SHL keeps rs2 data.
        issue(3'b110, 5'd1, 5'd2, 32'd1, 32'd9, 32'hFFFF_FFFF, 5'd4, 1'b1,
              32'd1, 32'hFFFF_FFFF, 3'b110, 1'b1);
        issue(3'b100, 5'd1, 5'd2, 32'd3, 32'd2, 32'd4, 5'd5, 1'b1, 32'd3, 32'd2, 3'b100, 1'b1);

        // Capture forwarding, then wb_rd==0 must not forward.
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'hDEAD;
        issue(3'b010, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0, 5'd6, 1'b1, 32'hDEAD, 32'd2, 3'b010, 1'b1);
        bus.wb_rd = 5'd0; bus.wb_data = 32'hBEEF;
        issue(3'b011, 5'd0, 5'd0, 32'h55, 32'h66, 32'd0, 5'd7, 1'b1, 32'h55, 32'h66, 3'b011, 1'b1);
        bus.wb_valid = 1'b0;
        cycles(2);

        // Back-to-back A,B,C under stall.
        bus.out_ready = 1'b0;
        issue(3'b010, 5'd1, 5'd2, 32'hA1, 32'hA2, 32'd0, 5'd10, 1'b1, 32'hA1, 32'hA2, 3'b010, 1'b1);
        issue(3'b011, 5'd1, 5'd2, 32'hB1, 32'hB2, 32'd0, 5'd11, 1'b1, 32'hB1, 32'hB2, 3'b011, 1'b1);
        check("stall_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        fork
            issue(3'b101, 5'd1, 5'd2, 32'hC1, 32'hC2, 32'd0, 5'd12, 1'b1,
                  32'hC1, 32'hC2, 3'b101, 1'b1);
            begin
                cycles(3);
                check("stall_hold_src_a", bus.src_a, 32'hA1);
                check("stall_hold_rd", {27'd0, bus.out_rd}, 32'd10);
                bus.out_ready = 1'b1;
            end
        join
        cycles(3);
        check("abc_drained", exp_q.size(), 32'd0);

        // Forwarding into a held, register-sourced rs2.
        bus.out_ready = 1'b0;
        issue(3'b011, 5'd7, 5'd6, 32'h20, 32'h3, 32'd0, 5'd8, 1'b1, 32'h20, 32'h11, 3'b011, 1'b1);
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h11;
        cycles(1);
        bus.wb_valid = 1'b0;
        check("held_fwd_src_b", bus.src_b, 32'h11);
        bus.out_ready = 1'b1;
        cycles(2);

        // Illegal op, sticky flag, rd==0 kills reg_write.
        issue(3'b001, 5'd1, 5'd2, 32'h7, 32'h8, 32'd0, 5'd2, 1'b1, 32'h7, 32'h8, 3'b000, 1'b0);
        check("illegal_set", {31'd0, bus.illegal_op}, 32'd1);
        issue(3'b010, 5'd1, 5'd2, 32'h1, 32'h1, 32'd0, 5'd0, 1'b1, 32'h1, 32'h1, 3'b010, 1'b0);
        issue(3'b000, 5'd1, 5'd2, 32'h2, 32'h3, 32'd0, 5'd9, 1'b1, 32'h2, 32'h3, 3'b000, 1'b1);
        cycles(2);
        check("illegal_sticky", {31'd0, bus.illegal_op}, 32'd1);

        // Flush with both entries full and a same-cycle input.
        bus.out_ready = 1'b0;
        issue(3'b010, 5'd1, 5'd2, 32'hF1, 32'hF2, 32'd0, 5'd13, 1'b1, 32'hF1, 32'hF2, 3'b010, 1'b1);
        issue(3'b010, 5'd1, 5'd2, 32'hF3, 32'hF4, 32'd0, 5'd14, 1'b1, 32'hF3, 32'hF4, 3'b010, 1'b1);
        bus.in_valid = 1'b1; bus.in_rd = 5'd15; bus.flush = 1'b1;
        cycles(1);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        cycles(4);

        // Asynchronous reset mid-stall.
        bus.out_ready = 1'b0;
        issue(3'b011, 5'd1, 5'd2, 32'h31, 32'h32, 32'd0, 5'd16, 1'b1, 32'h31, 32'h32, 3'b011, 1'b1);
        issue(3'b011, 5'd1, 5'd2, 32'h33, 32'h34, 32'd0, 5'd17, 1'b1, 32'h33, 32'h34, 3'b011, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("areset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("areset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("areset_src_a", bus.src_a, 32'd0);
        check("areset_src_b", bus.src_b, 32'd0);
        check("areset_alu_control", {29'd0, bus.alu_control}, 32'd0);
        check("areset_out_rd", {27'd0, bus.out_rd}, 32'd0);
        check("areset_reg_write", {31'd0, bus.out_reg_write}, 32'd0);
        check("areset_illegal", {31'd0, bus.illegal_op}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cycles(3);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
